uart_tx_cfg: RTL

Parametrised, buffered UART transmitter, successor to the fixed 8N1 serial transmit path. Accepts bytes over a valid/ready handshake into an internal FIFO and serialises them LSB-first. Frame format is run-time configurable: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits. Baud divider and oversample ratio are parameters. Sits between a byte producer (command or debug logic) and the board TX pin.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_tx_cfg.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame-format decode helpers for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    function automatic logic [3:0] data_bits(input logic [1:0] cfg);
        return 4'd5 + {2'b00, cfg};
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] cfg);
        return 8'hFF >> (2'd3 - cfg);
    endfunction

    // Code 3 is reserved and behaves as no parity.
    function automatic parity_e parity_decode(input logic [1:0] cfg);
        case (cfg)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every CLK_DIV clocks, re-phased by restart.
module uart_baud_tick #(
    parameter int CLK_DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with run-time frame format (5-8 data bits, parity, 1/2 stop).
//   state     | meaning
//   ST_IDLE   | line high; pop next byte and latch frame config
//   ST_START  | start bit (low) for one bit time
//   ST_DATA   | data bits LSB first, one per bit time
//   ST_PARITY | parity bit over the configured data bits
//   ST_STOP   | one or two stop bits (high)
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 651,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_valid,
    input  logic [7:0]                    tx_data,
    output logic                          tx_ready,
    input  logic [1:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(OVERSAMPLE);

    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           fifo_empty, do_write, do_pop;
    logic [7:0]     fifo_head;

    tx_state_e      state, state_d;
    logic [7:0]     shreg, shreg_d;
    logic [2:0]     bit_cnt, bit_cnt_d;
    logic [OW-1:0]  os_cnt;
    logic           tick, bit_end;
    logic [3:0]     nbits;
    parity_e        par_mode;
    logic           stop2, par_bit;
    logic           tx_d, tx_done_d;

    assign tx_ready   = (fifo_count != CW'(FIFO_DEPTH));
    assign do_write   = tx_valid && tx_ready;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_write) begin
            fifo_mem[wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (do_pop),
        .tick    (tick)
    );

    assign bit_end = tick && (os_cnt == OW'(OVERSAMPLE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            os_cnt <= '0;
        end else if (do_pop) begin
            os_cnt <= '0;
        end else if (tick) begin
            os_cnt <= (os_cnt == OW'(OVERSAMPLE - 1)) ? '0 : os_cnt + 1'b1;
        end
    end

    // The tx_done cycle is held in IDLE without popping, giving a two-cycle idle gap.
    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
        do_pop    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !tx_done) begin
                    do_pop    = 1'b1;
                    shreg_d   = fifo_head;
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = {1'b0, shreg[7:1]};
                    if ({1'b0, bit_cnt} == nbits - 4'd1) begin
                        bit_cnt_d = '0;
                        state_d   = (par_mode == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2 && (bit_cnt == 3'd0)) begin
                        bit_cnt_d = 3'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_bit;
            default:   tx_d = 1'b1;
        endcase
        tx_done_d = (state == ST_STOP) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            nbits    <= 4'd8;
            par_mode <= PAR_NONE;
            stop2    <= 1'b0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bit_cnt <= bit_cnt_d;
            tx      <= tx_d;
            tx_busy <= (state_d != ST_IDLE);
            tx_done <= tx_done_d;
            if (do_pop) begin
                nbits    <= data_bits(cfg_data_bits);
                par_mode <= parity_decode(cfg_parity);
                stop2    <= cfg_stop2;
                par_bit  <= (^(fifo_head & data_mask(cfg_data_bits)))
                            ^ (parity_decode(cfg_parity) == PAR_ODD);
            end
        end
    end

endmodule
